// File: rtl/keystream_xor_unit.sv
// rtl/keystream_xor_unit.sv - packs the generator keystream into W-bit key words and XORs them onto a data stream
// Free-running bits are absorbed continuously; a completed word that finds the key register full is dropped.
module keystream_xor_unit #(
  parameter int W       = 8,
  parameter int DISCARD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ks_set,
  input  logic         ks_bit,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         key_valid,
  output logic         overrun,
  output logic         running
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WARMUP = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;

  localparam int DW = (DISCARD > 1) ? $clog2(DISCARD) : 1;
  localparam int BW = $clog2(W);
  localparam logic [DW-1:0] DISC_LAST = DW'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);

  logic [1:0]    state;
  logic [DW-1:0] disc_cnt;
  logic [BW-1:0] bit_cnt;
  logic [W-1:0]  shift_reg;
  logic [W-1:0]  key;
  logic [W-1:0]  next_word;
  logic          xfer;
  logic          word_done;

  assign in_ready  = key_valid && (!out_valid || out_ready);
  assign xfer      = in_valid && in_ready;
  assign running   = (state == RUN);
  assign word_done = running && !ks_set && (bit_cnt == BIT_LAST);
  // MSB-first packing: the first bit after warm-up ends up in key[W-1]
  assign next_word = {shift_reg[W-2:0], ks_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      disc_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (ks_set) begin
      state     <= (DISCARD == 0) ? RUN : WARMUP;
      disc_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        WARMUP: begin
          disc_cnt <= disc_cnt + 1'b1;
          if (disc_cnt == DISC_LAST) state <= RUN;
        end
        RUN: begin
          shift_reg <= next_word;
          bit_cnt   <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A full key register keeps its old word unless that word leaves on this same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key       <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (ks_set) begin
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (word_done) begin
      if (key_valid && !xfer) begin
        overrun <= 1'b1;
      end else begin
        key       <= next_word;
        key_valid <= 1'b1;
      end
    end else if (xfer) begin
      key_valid <= 1'b0;
    end
  end

  // Output results survive a reseed; they were computed from the previous key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (xfer) begin
      out_data  <= in_data ^ key;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keystream_xor_unit.sv
// tb/tb_keystream_xor_unit.sv - scenario bench for keystream_xor_unit with a bit-queue key model
module tb_keystream_xor_unit;
  localparam int W    = 8;
  localparam int DISC = 4;

  logic         clk = 1'b0;
  logic         rst_n, ks_set, ks_bit, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid, key_valid, overrun, running;
  logic [W-1:0] out_data;
  logic         in_ready0, out_valid0, key_valid0, overrun0, running0;
  logic [W-1:0] out_data0;

  int tests  = 0;
  int errors = 0;
  bit bits_q[$];

  always #5 clk = ~clk;

  keystream_xor_unit #(.W(W), .DISCARD(DISC)) dut (
    .clk(clk), .rst_n(rst_n), .ks_set(ks_set), .ks_bit(ks_bit),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_valid(key_valid), .overrun(overrun), .running(running)
  );

  keystream_xor_unit #(.W(W), .DISCARD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ks_set(ks_set), .ks_bit(ks_bit),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .key_valid(key_valid0), .overrun(overrun0), .running(running0)
  );

  // Key word k is the W bits following the discarded prefix of the post-reseed stream, MSB first
  function automatic logic [W-1:0] key_word(input int disc, input int k);
    logic [W-1:0] kw = '0;
    for (int i = 0; i < W; i++) kw = {kw[W-2:0], logic'(bits_q[disc + k*W + i])};
    return kw;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(1, 0));
  endfunction

  task automatic cycle(input logic b);
    ks_bit = b;
    @(posedge clk);
    if (ks_set) bits_q.delete();
    else bits_q.push_back(b);
    #1;
  endtask

  task automatic reseed();
    ks_set = 1'b1;
    cycle(rb());
    ks_set = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ks_set = 1'b0; ks_bit = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, key_valid, overrun, running, in_ready} !== 5'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b kv=%b or=%b run=%b ir=%b od=%h expected all 0",
               out_valid, key_valid, overrun, running, in_ready, out_data);
    end
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(i[0]);
      tests++;
      if (in_ready !== 1'b0 || running !== 1'b0 || key_valid !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignores_bits: got ir=%b run=%b kv=%b ov=%b expected 0 0 0 0",
                 in_ready, running, key_valid, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] dpat = 4'b1010;
    logic [7:0] kpat = 8'hCA;
    reseed();
    tests++;
    if (running !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL warmup_entry: got run=%b kv=%b expected 0 0", running, key_valid);
    end
    for (int i = 0; i < DISC; i++) begin
      cycle(dpat[3-i]);
      tests++;
      if (running !== (i == DISC-1)) begin
        errors++;
        $display("FAIL warmup_running_%0d: got %b expected %b", i, running, (i == DISC-1));
      end
    end
    for (int i = 0; i < W; i++) begin
      cycle(kpat[7-i]);
      tests++;
      if (key_valid !== (i == W-1)) begin
        errors++;
        $display("FAIL key_valid_bit_%0d: got %b expected %b", i, key_valid, (i == W-1));
      end
    end
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
    tests++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_in_ready: got %b expected 1", in_ready);
    end
    cycle(rb());
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h90 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_cipher: got ov=%b od=%h kv=%b expected 1 90 0", out_valid, out_data, key_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_key, d;
    out_ready = 1'b0;
    for (int n = 0; n < W + 2 && key_valid !== 1'b1; n++) cycle(rb());
    tests++;
    if (key_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_key_timeout: got kv=%b expected 1", key_valid);
    end
    exp_key = key_word(DISC, 1);
    cycle(rb());
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h90) begin
      errors++;
      $display("FAIL bp_hold: got ir=%b ov=%b od=%h expected 0 1 90", in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    cycle(rb());
    tests++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got ov=%b expected 0", out_valid);
    end
    d = W'($urandom); in_valid = 1'b1; in_data = d;
    cycle(rb());
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || out_data !== (d ^ exp_key)) begin
      errors++;
      $display("FAIL bp_next_word: got ov=%b od=%h expected 1 %h", out_valid, out_data, d ^ exp_key);
    end
  endtask

  task automatic test_overrun();
    logic [W-1:0] d;
    in_valid = 1'b0; out_ready = 1'b1;
    reseed();
    repeat (DISC + W) cycle(rb());
    tests++;
    if (key_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first_word: got kv=%b or=%b expected 1 0", key_valid, overrun);
    end
    repeat (W - 1) cycle(rb());
    tests++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_early: got %b expected 0", overrun);
    end
    cycle(rb());
    tests++;
    if (overrun !== 1'b1 || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set: got or=%b kv=%b expected 1 1", overrun, key_valid);
    end
    d = W'($urandom); in_valid = 1'b1; in_data = d;
    cycle(rb());
    in_valid = 1'b0;
    tests++;
    if (out_data !== (d ^ key_word(DISC, 0)) || overrun !== 1'b1 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovr_old_key: got od=%h or=%b kv=%b expected %h 1 0",
               out_data, overrun, key_valid, d ^ key_word(DISC, 0));
    end
  endtask

  task automatic test_reseed_midword();
    logic [W-1:0] d, held;
    out_ready = 1'b1;
    reseed();
    tests++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reseed_clears_overrun: got %b expected 0", overrun);
    end
    repeat (DISC + W) cycle(rb());
    d = W'($urandom); in_valid = 1'b1; in_data = d; out_ready = 1'b0;
    cycle(rb());
    in_valid = 1'b0;
    held = d ^ key_word(DISC, 0);
    repeat (4) cycle(rb());
    reseed();
    tests++;
    if (key_valid !== 1'b0 || overrun !== 1'b0 || running !== 1'b0 || out_valid !== 1'b1 || out_data !== held) begin
      errors++;
      $display("FAIL reseed_mid: got kv=%b or=%b run=%b ov=%b od=%h expected 0 0 0 1 %h",
               key_valid, overrun, running, out_valid, out_data, held);
    end
    repeat (DISC + W) cycle(rb());
    tests++;
    if (key_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
      errors++;
      $display("FAIL reseed_pending: got kv=%b ir=%b od=%h expected 1 0 %h", key_valid, in_ready, out_data, held);
    end
    out_ready = 1'b1;
    cycle(rb());
    tests++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reseed_drain: got ov=%b expected 0", out_valid);
    end
    d = W'($urandom); in_valid = 1'b1; in_data = d;
    cycle(rb());
    in_valid = 1'b0;
    tests++;
    if (out_data !== (d ^ key_word(DISC, 0))) begin
      errors++;
      $display("FAIL reseed_new_key: got %h expected %h", out_data, d ^ key_word(DISC, 0));
    end
  endtask

  task automatic test_consume_on_completion();
    logic [W-1:0] d1, d2;
    out_ready = 1'b1; in_valid = 1'b0;
    reseed();
    repeat (DISC + W) cycle(rb());
    repeat (W - 1) cycle(rb());
    d1 = W'($urandom); in_valid = 1'b1; in_data = d1;
    cycle(rb());
    tests++;
    if (out_data !== (d1 ^ key_word(DISC, 0)) || key_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL coc_swap: got od=%h kv=%b or=%b expected %h 1 0",
               out_data, key_valid, overrun, d1 ^ key_word(DISC, 0));
    end
    d2 = W'($urandom); in_data = d2;
    cycle(rb());
    in_valid = 1'b0;
    tests++;
    if (out_data !== (d2 ^ key_word(DISC, 1))) begin
      errors++;
      $display("FAIL coc_new_word: got %h expected %h", out_data, d2 ^ key_word(DISC, 1));
    end
  endtask

  task automatic test_discard0();
    logic [7:0] kp = 8'hA5;
    logic [W-1:0] d;
    out_ready = 1'b1; in_valid = 1'b0;
    reseed();
    tests++;
    if (running0 !== 1'b1 || key_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL d0_running: got run=%b kv=%b expected 1 0", running0, key_valid0);
    end
    for (int i = 0; i < W; i++) cycle(kp[7-i]);
    tests++;
    if (key_valid0 !== 1'b1) begin
      errors++;
      $display("FAIL d0_key_valid: got %b expected 1", key_valid0);
    end
    in_valid = 1'b1; in_data = 8'hFF;
    cycle(rb());
    in_valid = 1'b0;
    tests++;
    if (out_valid0 !== 1'b1 || out_data0 !== 8'h5A) begin
      errors++;
      $display("FAIL d0_cipher: got ov=%b od=%h expected 1 5a", out_valid0, out_data0);
    end
    repeat (W - 1) cycle(rb());
    d = W'($urandom); in_valid = 1'b1; in_data = d;
    cycle(rb());
    in_valid = 1'b0;
    tests++;
    if (out_data0 !== (d ^ key_word(0, 1))) begin
      errors++;
      $display("FAIL d0_second_word: got %h expected %h", out_data0, d ^ key_word(0, 1));
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1; in_valid = 1'b0;
    reseed();
    repeat (DISC + W) cycle(rb());
    in_valid = 1'b1; in_data = W'($urandom); out_ready = 1'b0;
    cycle(rb());
    in_valid = 1'b0;
    for (int n = 0; n < W + 2 && key_valid !== 1'b1; n++) cycle(rb());
    tests++;
    if (key_valid !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup: got kv=%b ov=%b expected 1 1", key_valid, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, key_valid, overrun, running, in_ready} !== 5'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL areset_outputs: got ov=%b kv=%b or=%b run=%b ir=%b od=%h expected all 0",
               out_valid, key_valid, overrun, running, in_ready, out_data);
    end
    repeat (2) cycle(rb());
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(i[0]);
      tests++;
      if (in_ready !== 1'b0 || running !== 1'b0 || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL areset_idle: got ir=%b run=%b kv=%b expected 0 0 0", in_ready, running, key_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_reseed_midword();
    test_consume_on_completion();
    test_discard0();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/keystream_xor_unit.md
Name: keystream_xor_unit

Overview:
- Downstream consumer of the switching generator's serial keystream bit (`out`).
- Discards a warm-up prefix after each reseed.
- Packs the following bits into W-bit key words.
- XORs each key word with one input data word under valid/ready handshakes. The result is the cipher/plain output stream.
- The generator has no enable, so this block absorbs the free-running bitstream and flags lost key words.

Parameters:
W, 8, data/key word width in bits (>=2)
DISCARD, 16, keystream bits dropped after each reseed before packing starts (>=0)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ks_set  input  1  same signal that drives the generator's set; high = generator being seeded
ks_bit  input  1  generator serial output, one bit per clk
in_valid  input  1  input word valid
in_ready  output  1  input word accepted this cycle when in_valid and in_ready
in_data  input  W  plaintext/ciphertext word
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts out_data
out_data  output  W  in_data XOR key word
key_valid  output  1  a packed key word is held and ready for use
overrun  output  1  sticky: a completed key word was dropped because the key register was full
running  output  1  state == RUN

Behaviour:
- Reset (rst_n low, async):
  - State IDLE.
  - Discard counter, bit counter and shift register cleared.
  - key_valid=0, out_valid=0, out_data=0, overrun=0, running=0.
- States:
  - IDLE: no key material. Ignores ks_bit.
  - WARMUP: discarding the prefix.
  - RUN: packing bits.
- Reseed: any cycle with ks_set=1, from any state:
  - Next state WARMUP; or RUN directly if DISCARD==0.
  - Discard counter, bit counter and shift register cleared.
  - key_valid=0, overrun=0.
  - ks_bit is not sampled while ks_set=1.
  - out_valid/out_data are preserved, since they are already-computed results.
- WARMUP:
  - Each cycle with ks_set=0 consumes one ks_bit and increments the discard counter.
  - The cycle consuming discard bit DISCARD-1 moves to RUN.
  - The first RUN-state bit is the first packed bit.
- RUN packing:
  - Each cycle with ks_set=0, shift_reg <= {shift_reg[W-2:0], ks_bit}, and the bit counter increments mod W.
  - The first packed bit therefore lands in key[W-1] (MSB-first).
- Word completion (the cycle the W-th bit is sampled):
  - Next cycle the key register holds the new word and key_valid=1. Latency is 1 clk after the last bit.
  - If key_valid=1 and the key word is not consumed in the completion cycle, the new word is dropped: the key register keeps the old word and overrun<=1 (sticky until reseed or reset).
  - If the old key is consumed in the same cycle, the new word loads with no overrun.
  - Packing continues regardless.
- Handshake:
  - in_ready = key_valid && (!out_valid || out_ready). This is combinational; no path from in_valid to in_ready.
  - Transfer when in_valid && in_ready: next edge out_data <= in_data ^ key, out_valid <= 1, and the key is consumed (key_valid cleared unless a new word loads that same edge).
  - out_valid clears when out_ready=1 and no new transfer occurs that cycle.
  - out_data and out_valid are stable while out_valid && !out_ready.
- Throughput: at most one word per W clocks, bounded by the keystream rate.
- IDLE: in_ready=0 always.

Test Plan:
- Reset: assert rst_n=0 mid-run with key_valid=1, out_valid=1 -> all outputs 0 asynchronously; state IDLE; in_ready=0 while ks_bit toggles with no set.
- Basic cipher (W=8, DISCARD=4):
  - Stimulus: ks_set 1 cycle, then bits 1,0,1,0 (discarded), then 1,1,0,0,1,0,1,0.
  - Expected: key_valid rises 1 clk after the 8th packed bit with key=0xCA.
  - in_data=0x5A accepted -> out_data=0x90, out_valid next clk.
- Backpressure: hold out_ready=0 with out_valid=1 -> in_ready=0 though key_valid=1; out_data stable. Release -> drain, then next word accepted.
- Overrun:
  - Hold in_valid=0 across two full key words -> overrun=1 after the 2nd completion; key register still holds the first word.
  - Consume on the exact completion cycle instead -> overrun stays 0 and the new word loads.
- Reseed mid-word: ks_set=1 after 5 packed bits -> key_valid=0, overrun=0, running=0; the next word uses only post-warm-up bits. A pending out_valid word is still delivered intact.
- DISCARD=0: ks_set then bits 0xA5 MSB-first -> running=1 in the first cycle after set; key=0xA5; in_data=0xFF -> out_data=0x5A.
